jpeg_dequant: RTL and testbench

Parametrised dequantiser and de-zigzag stage for the baseline/extended JPEG decoder. It sits between the Huffman/RLE coefficient decoder and the IDCT. It loads quantisation tables from the DQT segment byte stream, with 8-bit (Pq=0) or 16-bit (Pq=1) entries and multiple tables per segment. Each coefficient is multiplied by its table entry and saturated. Unlike the previous generation, it supports full valid/accept backpressure.

---
 rtl/jpeg_pkg.sv | 34 +++
 rtl/jpeg_dequant_ram.sv | 25 ++
 rtl/jpeg_dequant.sv | 225 ++++++++++++++++++++++
 tb/tb_jpeg_dequant.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG dequantiser: config FSM encoding,
// component codes and the zigzag-to-natural index mapping.
package jpeg_pkg;

  typedef enum logic [1:0] {
    CFG_HDR    = 2'd0,
    CFG_ENT_HI = 2'd1,
    CFG_ENT_LO = 2'd2
  } cfg_state_t;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;
  localparam logic [1:0] COMP_K  = 2'd3;

  localparam int TBL_ENTRIES = 64;

  // Natural (row-major) position of each zigzag scan position.
  localparam logic [5:0] ZZ_TO_NAT [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [5:0] dezigzag(input logic [5:0] zz);
    return ZZ_TO_NAT[zz];
  endfunction

endpackage

// File: rtl/jpeg_dequant_ram.sv
// Quantisation table store: NUM_TABLES x 64 entries of 16 bits, one port,
// synchronous read. A write cycle leaves the read register untouched so a
// stalled reader keeps seeing the same entry.
module jpeg_dequant_ram #(
  parameter int NUM_TABLES = 4,
  parameter int AW         = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  localparam int DEPTH = NUM_TABLES * 64;

  logic [15:0] mem [DEPTH];

  // Single port: write takes precedence, otherwise register the addressed entry.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    else      rdata_o     <= mem[addr_i];
  end

endmodule

// File: rtl/jpeg_dequant.sv
// Dequantiser / de-zigzag stage between the coefficient decoder and the IDCT.
// Loads quantisation tables from the DQT payload byte stream, multiplies each
// coefficient by its table entry, saturates, and remaps the index to natural
// order. Two register stages with valid/accept backpressure.
module jpeg_dequant
  import jpeg_pkg::*;
#(
  parameter int NUM_TABLES = 4,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 16,
  parameter bit ZIGZAG_EN  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             img_start_i,
  input  logic [1:0]       img_dqt_table_y_i,
  input  logic [1:0]       img_dqt_table_cb_i,
  input  logic [1:0]       img_dqt_table_cr_i,
  input  logic             cfg_valid_i,
  input  logic [7:0]       cfg_data_i,
  input  logic             cfg_last_i,
  output logic             cfg_accept_o,
  output logic             cfg_err_o,
  input  logic             inport_valid_i,
  input  logic [IN_W-1:0]  inport_data_i,
  input  logic [5:0]       inport_idx_i,
  input  logic [31:0]      inport_id_i,
  input  logic             inport_eob_i,
  output logic             inport_accept_o,
  output logic             outport_valid_o,
  output logic [OUT_W-1:0] outport_data_o,
  output logic [5:0]       outport_idx_o,
  output logic [31:0]      outport_id_o,
  output logic             outport_eob_o,
  input  logic             outport_accept_i
);

  localparam int         PW  = IN_W + 17;
  localparam int         AW  = (NUM_TABLES > 1) ? $clog2(NUM_TABLES * 64) : 6;
  localparam logic [3:0] NT4 = 4'(NUM_TABLES);

  // Clamp the full-width product into the signed output range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] max_v;
    logic signed [PW-1:0] min_v;
    max_v = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    min_v = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    if (p > max_v)      return max_v[OUT_W-1:0];
    else if (p < min_v) return min_v[OUT_W-1:0];
    else                return p[OUT_W-1:0];
  endfunction

  // Config state
  cfg_state_t cfg_state;
  logic       pq16;
  logic [3:0] tq;
  logic [5:0] cnt;
  logic [7:0] hi_byte;
  logic       cfg_err;

  logic cfg_wr_slot;
  logic ram_we;
  logic hdr_bad;
  logic last_bad;

  // Pipeline state
  logic                    vld_p1;
  logic signed [IN_W-1:0]  data_p1;
  logic [5:0]              idx_p1;
  logic [31:0]             id_p1;
  logic                    eob_p1;
  logic [1:0]              tsel_p1;

  logic                    vld_p2;
  logic signed [OUT_W-1:0] data_p2;
  logic [5:0]              idx_p2;
  logic [31:0]             id_p2;
  logic                    eob_p2;

  logic                    adv;
  logic                    in_accept;
  logic                    in_fire;
  logic [1:0]              tsel_in;
  logic [7:0]              raddr;
  logic [7:0]              waddr;
  logic [15:0]             ram_rdata;
  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    b_ext;
  logic signed [PW-1:0]    prod_p1;

  // A byte arriving in ENT_LO owns the RAM port this cycle.
  assign cfg_wr_slot = cfg_valid_i && (cfg_state == CFG_ENT_LO);
  assign ram_we      = cfg_wr_slot && (tq < NT4);
  assign hdr_bad     = (cfg_state == CFG_HDR) && (cfg_data_i[3:0] >= NT4);
  assign last_bad    = cfg_last_i && !((cfg_state == CFG_ENT_LO) && (cnt == 6'd63));
  assign waddr       = {tq[1:0], cnt};

  assign cfg_accept_o = 1'b1;
  assign cfg_err_o    = cfg_err;

  // DQT payload parser: header byte, then 64 entries of one or two bytes each.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_state <= CFG_HDR;
      pq16      <= 1'b0;
      tq        <= 4'd0;
      cnt       <= 6'd0;
      hi_byte   <= 8'd0;
      cfg_err   <= 1'b0;
    end else begin
      if (img_start_i)
        cfg_err <= 1'b0;
      else if (cfg_valid_i && (hdr_bad || last_bad))
        cfg_err <= 1'b1;

      if (cfg_valid_i) begin
        case (cfg_state)
          CFG_HDR: begin
            pq16      <= (cfg_data_i[7:4] == 4'd1);
            tq        <= cfg_data_i[3:0];
            cnt       <= 6'd0;
            cfg_state <= (cfg_data_i[7:4] == 4'd1) ? CFG_ENT_HI : CFG_ENT_LO;
          end
          CFG_ENT_HI: begin
            hi_byte   <= cfg_data_i;
            cfg_state <= CFG_ENT_LO;
          end
          CFG_ENT_LO: begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd63)  cfg_state <= CFG_HDR;
            else if (pq16)     cfg_state <= CFG_ENT_HI;
            else               cfg_state <= CFG_ENT_LO;
          end
          default: cfg_state <= CFG_HDR;
        endcase
        if (cfg_last_i) cfg_state <= CFG_HDR;
      end
    end
  end

  // Pick the table for the incoming coefficient from its component field.
  always_comb begin
    tsel_in = 2'd0;
    case (inport_id_i[31:30])
      COMP_Y:  tsel_in = img_dqt_table_y_i;
      COMP_CB: tsel_in = img_dqt_table_cb_i;
      COMP_CR: tsel_in = img_dqt_table_cr_i;
      COMP_K:  tsel_in = 2'd0;
      default: tsel_in = 2'd0;
    endcase
  end

  assign adv       = !vld_p2 || outport_accept_i;
  assign in_accept = !rst_i && adv && !cfg_wr_slot && !img_start_i;
  assign in_fire   = inport_valid_i && in_accept;
  assign inport_accept_o = in_accept;

  // New coefficient reads its entry; otherwise S1 keeps re-reading its own.
  assign raddr = in_fire ? {tsel_in, inport_idx_i} : {tsel_p1, idx_p1};

  jpeg_dequant_ram #(
    .NUM_TABLES (NUM_TABLES),
    .AW         (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_we ? AW'(waddr) : AW'(raddr)),
    .wdata_i ({pq16 ? hi_byte : 8'h00, cfg_data_i}),
    .rdata_o (ram_rdata)
  );

  // ---- Stage p1: coefficient captured, table entry being read ----
  // S1 payload registers; only meaningful while vld_p1 is set.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      data_p1 <= inport_data_i;
      idx_p1  <= inport_idx_i;
      id_p1   <= inport_id_i;
      eob_p1  <= inport_eob_i;
      tsel_p1 <= tsel_in;
    end
  end

  // Entry is unsigned 16-bit, so widen it with a zero sign bit before multiplying.
  assign a_ext   = PW'(data_p1);
  assign b_ext   = PW'($signed({1'b0, ram_rdata}));
  assign prod_p1 = a_ext * b_ext;

  // Stage valids advance together; image start empties both stages.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (img_start_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_fire;
      vld_p2 <= vld_p1;
    end
  end

  // ---- Stage p2: saturated product and natural-order index at the output ----
  // Output registers only move when downstream can take them, which holds them under stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_p2 <= '0;
      idx_p2  <= 6'd0;
      id_p2   <= 32'd0;
      eob_p2  <= 1'b0;
    end else if (adv && vld_p1) begin
      data_p2 <= sat_out(prod_p1);
      idx_p2  <= ZIGZAG_EN ? dezigzag(idx_p1) : idx_p1;
      id_p2   <= id_p1;
      eob_p2  <= eob_p1;
    end
  end

  assign outport_valid_o = vld_p2;
  assign outport_data_o  = data_p2;
  assign outport_idx_o   = idx_p2;
  assign outport_id_o    = id_p2;
  assign outport_eob_o   = eob_p2;

endmodule

// File: tb/tb_jpeg_dequant.sv
// Bench for jpeg_dequant: a de-zigzag instance and a bypass instance share all
// inputs; a scoreboard per instance holds the expected outputs.
module tb_jpeg_dequant;

  logic        clk = 1'b0;
  logic        rst;
  logic        img_start;
  logic [1:0]  tsel_y, tsel_cb, tsel_cr;
  logic        cfg_valid;
  logic [7:0]  cfg_data;
  logic        cfg_last;
  logic        in_valid;
  logic [15:0] in_data;
  logic [5:0]  in_idx;
  logic [31:0] in_id;
  logic        in_eob;
  logic        out_acc;

  logic        cfg_acc, cfg_err, in_acc, o_valid, o_eob;
  logic [15:0] o_data;
  logic [5:0]  o_idx;
  logic [31:0] o_id;
  logic        b_cfg_acc, b_cfg_err, b_in_acc, b_valid, b_eob;
  logic [15:0] b_data;
  logic [5:0]  b_idx;
  logic [31:0] b_id;

  always #5 clk = ~clk;

  jpeg_dequant #(.NUM_TABLES(4), .IN_W(16), .OUT_W(16), .ZIGZAG_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .img_start_i(img_start),
    .img_dqt_table_y_i(tsel_y), .img_dqt_table_cb_i(tsel_cb), .img_dqt_table_cr_i(tsel_cr),
    .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data), .cfg_last_i(cfg_last),
    .cfg_accept_o(cfg_acc), .cfg_err_o(cfg_err),
    .inport_valid_i(in_valid), .inport_data_i(in_data), .inport_idx_i(in_idx),
    .inport_id_i(in_id), .inport_eob_i(in_eob), .inport_accept_o(in_acc),
    .outport_valid_o(o_valid), .outport_data_o(o_data), .outport_idx_o(o_idx),
    .outport_id_o(o_id), .outport_eob_o(o_eob), .outport_accept_i(out_acc)
  );

  jpeg_dequant #(.NUM_TABLES(4), .IN_W(16), .OUT_W(16), .ZIGZAG_EN(1'b0)) dut_bp (
    .clk_i(clk), .rst_i(rst), .img_start_i(img_start),
    .img_dqt_table_y_i(tsel_y), .img_dqt_table_cb_i(tsel_cb), .img_dqt_table_cr_i(tsel_cr),
    .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data), .cfg_last_i(cfg_last),
    .cfg_accept_o(b_cfg_acc), .cfg_err_o(b_cfg_err),
    .inport_valid_i(in_valid), .inport_data_i(in_data), .inport_idx_i(in_idx),
    .inport_id_i(in_id), .inport_eob_i(in_eob), .inport_accept_o(b_in_acc),
    .outport_valid_o(b_valid), .outport_data_o(b_data), .outport_idx_o(b_idx),
    .outport_id_o(b_id), .outport_eob_o(b_eob), .outport_accept_i(out_acc)
  );

  typedef struct {
    logic [15:0] data;
    logic [5:0]  idx;
    logic [31:0] id;
    logic        eob;
  } exp_t;

  exp_t q[$];
  exp_t q_bp[$];
  exp_t m_e;
  exp_t m_b;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  logic [15:0] tbl [4][64];
  int zz_nat [64];

  logic        hold_v = 1'b0;
  logic [54:0] hold_bus;

  // Natural-order index of each zigzag position, walked diagonal by diagonal.
  function automatic void build_zigzag();
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 8) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_nat[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_nat[k] = r * 8 + (s - r); k++; end
      end
    end
  endfunction

  function automatic logic [15:0] exp_data(input int c, input logic [15:0] e);
    longint p;
    p = longint'(c) * longint'(e);
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  function automatic logic [1:0] tsel_of(input logic [1:0] comp);
    case (comp)
      2'd0:    return tsel_y;
      2'd1:    return tsel_cb;
      2'd2:    return tsel_cr;
      default: return 2'd0;
    endcase
  endfunction

  // Output monitor: stall-hold check and in-order scoreboard comparison.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_v && o_valid) begin
        total++;
        if ({o_data, o_idx, o_id, o_eob} !== hold_bus) begin
          bad++;
          $display("FAIL out_hold: got %h required %h", {o_data, o_idx, o_id, o_eob}, hold_bus);
        end
      end
      hold_v   = o_valid && !out_acc;
      hold_bus = {o_data, o_idx, o_id, o_eob};
      if (o_valid && out_acc) begin
        rx_cnt++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected: got data=%h idx=%0d id=%h, required none", o_data, o_idx, o_id);
        end else begin
          m_e = q.pop_front();
          if (o_data !== m_e.data || o_idx !== m_e.idx || o_id !== m_e.id || o_eob !== m_e.eob) begin
            bad++;
            $display("FAIL out_zz: got data=%h idx=%0d id=%h eob=%b required data=%h idx=%0d id=%h eob=%b",
                     o_data, o_idx, o_id, o_eob, m_e.data, m_e.idx, m_e.id, m_e.eob);
          end
        end
      end
      if (b_valid && out_acc) begin
        total++;
        if (q_bp.size() == 0) begin
          bad++;
          $display("FAIL bp_unexpected: got data=%h idx=%0d, required none", b_data, b_idx);
        end else begin
          m_b = q_bp.pop_front();
          if (b_data !== m_b.data || b_idx !== m_b.idx || b_id !== m_b.id || b_eob !== m_b.eob) begin
            bad++;
            $display("FAIL out_bypass: got data=%h idx=%0d id=%h eob=%b required data=%h idx=%0d id=%h eob=%b",
                     b_data, b_idx, b_id, b_eob, m_b.data, m_b.idx, m_b.id, m_b.eob);
          end
        end
      end
    end
  end

  task automatic cfg_byte(input logic [7:0] b, input bit l);
    cfg_valid = 1'b1;
    cfg_data  = b;
    cfg_last  = l;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic cfg_table(input int tq, input int pq, input logic [15:0] val, input int n, input bit last);
    logic [7:0] hdr;
    hdr = {4'(pq), 4'(tq)};
    cfg_byte(hdr, last && (n == 0));
    for (int i = 0; i < n; i++) begin
      if (pq == 1) cfg_byte(val[15:8], 1'b0);
      cfg_byte(val[7:0], last && (i == n - 1));
      if (tq < 4) tbl[tq][i] = (pq == 1) ? val : {8'h00, val[7:0]};
    end
  endtask

  task automatic send_coef(input int coef, input int idx, input logic [1:0] comp,
                           input logic [29:0] tag, input bit eob, input bit push);
    bit acc;
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_data  = 16'(coef);
    in_idx   = 6'(idx);
    in_id    = {comp, tag};
    in_eob   = eob;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_acc;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL coef_accept_timeout: got no accept in %0d cycles, required accept", n);
    end else if (push) begin
      e.data = exp_data(coef, tbl[tsel_of(comp)][idx]);
      e.idx  = 6'(zz_nat[idx]);
      e.id   = {comp, tag};
      e.eob  = eob;
      q.push_back(e);
      e.idx  = 6'(idx);
      q_bp.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q_bp.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (q.size() != 0 || q_bp.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d/%0d outstanding, required 0", q.size(), q_bp.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({o_valid, o_data, o_idx, o_id, o_eob} !== 55'd0) begin
      bad++;
      $display("FAIL reset_out: got %h required 0", {o_valid, o_data, o_idx, o_id, o_eob});
    end
    total++;
    if (in_acc !== 1'b0 || cfg_acc !== 1'b1 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: got in_acc=%b cfg_acc=%b err=%b required 0 1 0", in_acc, cfg_acc, cfg_err);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_acc !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_accept: got %b required 1", in_acc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_pq0_load();
    cfg_table(0, 0, 16'h0002, 64, 1'b1);
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL pq0_err: got %b required 0", cfg_err);
    end
    send_coef(5, 2, 2'd0, 30'h11, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: got valid=%b required 0", o_valid);
    end
    @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_data !== 16'd10 || o_idx !== 6'd8) begin
      bad++;
      $display("FAIL latency_2: got valid=%b data=%0d idx=%0d required 1 10 8", o_valid, o_data, o_idx);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_pq1_multi();
    cfg_table(1, 1, 16'h0102, 64, 1'b0);
    cfg_table(2, 0, 16'h0003, 64, 1'b1);
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL pq1_err: got %b required 0", cfg_err);
    end
    send_coef(1, 10, 2'd1, 30'h21, 1'b0, 1'b1);
    send_coef(3, 0, 2'd1, 30'h22, 1'b0, 1'b1);
    send_coef(-4, 63, 2'd2, 30'h23, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_saturation();
    cfg_table(3, 1, 16'hFFFF, 64, 1'b1);
    tsel_cr = 2'd3;
    send_coef(-1000, 4, 2'd2, 30'h31, 1'b0, 1'b1);
    send_coef(1000, 17, 2'd2, 30'h32, 1'b0, 1'b1);
    send_coef(0, 9, 2'd2, 30'h33, 1'b0, 1'b1);
    send_coef(-7, 40, 2'd3, 30'h34, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    int start_rx;
    start_rx = rx_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send_coef((i - 5) * 13, (i * 7) % 64, 2'(i % 3), 30'(16'h100 + i), i == 9, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_acc = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_acc = 1'b1;
      end
    join
    drain();
    total++;
    if (rx_cnt - start_rx !== 10) begin
      bad++;
      $display("FAIL burst_count: got %0d required 10", rx_cnt - start_rx);
    end
  endtask

  task automatic test_bypass();
    cfg_byte(8'h00, 1'b0);
    cfg_valid = 1'b1;
    cfg_data  = 8'h02;
    in_valid  = 1'b1;
    in_data   = 16'd6;
    in_idx    = 6'd2;
    in_id     = {2'd0, 30'h41};
    in_eob    = 1'b0;
    @(negedge clk);
    total++;
    if (in_acc !== 1'b0 || b_in_acc !== 1'b0) begin
      bad++;
      $display("FAIL cfg_priority: got accept=%b/%b required 0", in_acc, b_in_acc);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    tbl[0][0] = 16'h0002;
    send_coef(6, 2, 2'd0, 30'h41, 1'b1, 1'b1);
    for (int i = 1; i < 64; i++) begin
      cfg_byte(8'h02, i == 63);
      tbl[0][i] = 16'h0002;
    end
    drain();
  endtask

  task automatic test_error_tq();
    cfg_table(7, 0, 16'h0055, 64, 1'b1);
    total++;
    if (cfg_err !== 1'b1 || b_cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL err_tq: got %b/%b required 1", cfg_err, b_cfg_err);
    end
    send_coef(-1, 5, 2'd2, 30'h51, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_img_start();
    out_acc = 1'b0;
    send_coef(11, 3, 2'd0, 30'h61, 1'b0, 1'b0);
    send_coef(12, 4, 2'd0, 30'h62, 1'b1, 1'b0);
    img_start = 1'b1;
    @(posedge clk); #1;
    img_start = 1'b0;
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0 || cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL img_start_flush: got valid=%b err=%b required 0 0", o_valid, cfg_err);
    end
    @(posedge clk); #1;
    out_acc   = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'd9;
    in_idx    = 6'd1;
    in_id     = {2'd0, 30'h63};
    img_start = 1'b1;
    @(negedge clk);
    total++;
    if (in_acc !== 1'b0) begin
      bad++;
      $display("FAIL img_start_accept: got %b required 0", in_acc);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    img_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_error_partial();
    cfg_table(1, 0, 16'h0009, 10, 1'b1);
    total++;
    if (cfg_err !== 1'b1) begin
      bad++;
      $display("FAIL err_partial: got %b required 1", cfg_err);
    end
    img_start = 1'b1;
    @(posedge clk); #1;
    img_start = 1'b0;
    total++;
    if (cfg_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: got %b required 0", cfg_err);
    end
    send_coef(2, 3, 2'd1, 30'h71, 1'b1, 1'b1);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    build_zigzag();
    rst = 1'b1; img_start = 1'b0;
    tsel_y = 2'd0; tsel_cb = 2'd1; tsel_cr = 2'd2;
    cfg_valid = 1'b0; cfg_data = 8'd0; cfg_last = 1'b0;
    in_valid = 1'b0; in_data = 16'd0; in_idx = 6'd0; in_id = 32'd0; in_eob = 1'b0;
    out_acc = 1'b1;
    test_reset();
    test_pq0_load();
    test_pq1_multi();
    test_saturation();
    test_back_to_back();
    test_bypass();
    test_error_tq();
    test_img_start();
    test_error_partial();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
